// File: rtl/lsu_mem_master.sv
// Load/store initiator between the MEM stage and the data-memory port.
// Accepts one request at a time, drives the memory for one cycle and returns a registered response.

package lsu_mem_pkg;
    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_SB  = 3'b011;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;
    localparam logic [2:0] MEM_SH  = 3'b110;
    localparam logic [2:0] MEM_SW  = 3'b111;
endpackage

module lsu_mem_master
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_base,
    input  logic [11:0]           req_offset,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [1:0]            resp_cause,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_op,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_wr,
    input  logic [DATA_WIDTH-1:0] mem_data_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] ea;
    logic [2:0]            op_map;
    logic                  illegal;
    logic                  misaligned;
    logic [1:0]            cause;
    logic                  accept;

    logic [2:0]            op_q, op_d;
    logic                  is_store_q, is_store_d;
    logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic [1:0]            resp_cause_q, resp_cause_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_wr_q, mem_data_wr_d;

    // Request decode: effective address, op mapping, legality and alignment.
    always_comb begin
        ea         = req_base + {{(ADDR_WIDTH-12){req_offset[11]}}, req_offset};
        op_map     = MEM_LW;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_is_store) begin
            case (req_funct3)
                3'b000:  op_map = MEM_SB;
                3'b001:  op_map = MEM_SH;
                3'b010:  op_map = MEM_SW;
                default: illegal = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000:  op_map = MEM_LB;
                3'b001:  op_map = MEM_LH;
                3'b010:  op_map = MEM_LW;
                3'b100:  op_map = MEM_LBU;
                3'b101:  op_map = MEM_LHU;
                default: illegal = 1'b1;
            endcase
        end
        case (req_funct3[1:0])
            2'b01:   misaligned = ea[0];
            2'b10:   misaligned = |ea[1:0];
            default: misaligned = 1'b0;
        endcase
        if (illegal) begin
            cause = 2'b11;
        end else if (misaligned) begin
            cause = req_is_store ? 2'b10 : 2'b01;
        end else begin
            cause = 2'b00;
        end
    end

    assign accept = (state_q == IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (cause == 2'b00) ? ACCESS : RESP;
                end
            end
            ACCESS:  state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE) && !rst;
        resp_valid = (state_q == RESP);
        mem_wr_en  = (state_q == ACCESS) && is_store_q;
        mem_op     = (state_q == ACCESS) ? op_q : MEM_LW;
    end

    // mem_addr/mem_data_wr are only reloaded for legal accesses so they hold otherwise.
    always_comb begin
        op_d          = op_q;
        is_store_d    = is_store_q;
        resp_addr_d   = resp_addr_q;
        resp_rdata_d  = resp_rdata_q;
        resp_err_d    = resp_err_q;
        resp_cause_d  = resp_cause_q;
        mem_addr_d    = mem_addr_q;
        mem_data_wr_d = mem_data_wr_q;
        if (accept) begin
            op_d         = op_map;
            is_store_d   = req_is_store;
            resp_addr_d  = ea;
            resp_rdata_d = '0;
            resp_err_d   = (cause != 2'b00);
            resp_cause_d = cause;
            if (cause == 2'b00) begin
                mem_addr_d = ea;
                if (req_is_store) begin
                    mem_data_wr_d = req_wdata;
                end
            end
        end else if (state_q == ACCESS && !is_store_q) begin
            resp_rdata_d = mem_data_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= MEM_LW;
            is_store_q    <= 1'b0;
            resp_addr_q   <= '0;
            resp_rdata_q  <= '0;
            resp_err_q    <= 1'b0;
            resp_cause_q  <= 2'b00;
            mem_addr_q    <= '0;
            mem_data_wr_q <= '0;
        end else begin
            op_q          <= op_d;
            is_store_q    <= is_store_d;
            resp_addr_q   <= resp_addr_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            resp_cause_q  <= resp_cause_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_wr_q <= mem_data_wr_d;
        end
    end

    assign resp_addr   = resp_addr_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign resp_cause  = resp_cause_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_wr = mem_data_wr_q;

endmodule
